// File: rtl/control_id_ex_mem_pkg.sv
// Shared definitions for the decode control unit and the ID/EX, EX/MEM
// pipeline registers: datapath widths, opcode map, control-field encodings
// and the control bundle carried down the pipe.
package control_id_ex_mem_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Opcode map
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_MUL   = 6'h08;
  localparam logic [5:0] OP_ADDI  = 6'h11;
  localparam logic [5:0] OP_MULI  = 6'h18;
  localparam logic [5:0] OP_LOAD  = 6'h20;
  localparam logic [5:0] OP_STORE = 6'h21;
  localparam logic [5:0] OP_MOVI  = 6'h22;
  localparam logic [5:0] OP_JUMP  = 6'h30;

  // Writeback source select
  localparam logic [1:0] M2R_MEM = 2'd0;
  localparam logic [1:0] M2R_ALU = 2'd1;
  localparam logic [1:0] M2R_IMM = 2'd2;

  // ALU B-operand select
  localparam logic ALUSRC_RD2 = 1'b0;
  localparam logic ALUSRC_IMM = 1'b1;

  // Immediate format select
  localparam logic [1:0] IMM_10 = 2'd0;
  localparam logic [1:0] IMM_15 = 2'd1;
  localparam logic [1:0] IMM_20 = 2'd2;

  // ALU op codes (register/immediate ops reuse opcode[3:0])
  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;

  // Control fields that travel with an instruction into Execute
  typedef struct packed {
    logic [1:0] mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic [4:0] alu_control;
    logic       reg_write;
  } ctrl_t;

  // True for the ALU op slot 1..8 within a 16-opcode group
  function automatic logic is_alu_slot(input logic [3:0] lo);
    return (lo >= 4'd1) && (lo <= 4'd8);
  endfunction

endpackage

// File: rtl/control_id_ex_mem_decoder.sv
// control_decoder: purely combinational opcode -> control mapping.
// Every field defaults to 0, so unknown opcodes behave as NOP.
// Ports:
//   opcode      in  decode-stage opcode
//   pc_src      out 1 = load PC with branch target
//   imm_src     out immediate format select
//   mem_to_reg  out writeback source select
//   mem_write   out data RAM write enable
//   alu_src     out ALU B-operand select
//   alu_control out ALU operation
//   reg_write   out register file write enable
module control_decoder
  import control_id_ex_mem_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       pc_src,
  output logic [1:0] imm_src,
  output logic [1:0] mem_to_reg,
  output logic       mem_write,
  output logic       alu_src,
  output logic [4:0] alu_control,
  output logic       reg_write
);

  always_comb begin
    pc_src      = 1'b0;
    imm_src     = IMM_10;
    mem_to_reg  = M2R_MEM;
    mem_write   = 1'b0;
    alu_src     = ALUSRC_RD2;
    alu_control = ALU_NOP;
    reg_write   = 1'b0;
    if (opcode[5:4] == 2'b00 && is_alu_slot(opcode[3:0])) begin
      reg_write   = 1'b1;
      mem_to_reg  = M2R_ALU;
      alu_src     = ALUSRC_RD2;
      alu_control = {1'b0, opcode[3:0]};
    end else if (opcode[5:4] == 2'b01 && is_alu_slot(opcode[3:0])) begin
      reg_write   = 1'b1;
      mem_to_reg  = M2R_ALU;
      alu_src     = ALUSRC_IMM;
      imm_src     = IMM_10;
      alu_control = {1'b0, opcode[3:0]};
    end else begin
      case (opcode)
        OP_LOAD: begin
          reg_write   = 1'b1;
          mem_to_reg  = M2R_MEM;
          alu_src     = ALUSRC_IMM;
          imm_src     = IMM_15;
          alu_control = ALU_ADD;
        end
        OP_STORE: begin
          mem_write   = 1'b1;
          alu_src     = ALUSRC_IMM;
          imm_src     = IMM_15;
          alu_control = ALU_ADD;
        end
        OP_MOVI: begin
          reg_write   = 1'b1;
          mem_to_reg  = M2R_IMM;
          imm_src     = IMM_20;
        end
        OP_JUMP: begin
          pc_src      = 1'b1;
          imm_src     = IMM_20;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_id_ex_mem.sv
// Decode control unit plus ID/EX and EX/MEM pipeline registers.
// Both registers load every clock (no stall/flush) and clear asynchronously
// on rst=0, which leaves NOPs (no reg/mem writes) in both stages.
// Ports:
//   clk, rst            clock, async active-low reset
//   opcode              decode-stage opcode
//   pc_src, imm_src     combinational control for the decode/fetch stages
//   pc_count..rd        decode-stage operands
//   alu_Result          Execute-stage ALU output
//   ex_*                ID/EX register contents
//   mem_*               EX/MEM register contents
module control_id_ex_mem
  import control_id_ex_mem_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    opcode,
  output logic          pc_src,
  output logic [1:0]    imm_src,
  input  logic [DW-1:0] pc_count,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2,
  input  logic [DW-1:0] signImm,
  input  logic [RW-1:0] rd,
  input  logic [DW-1:0] alu_Result,
  output logic [1:0]    ex_mem_to_reg,
  output logic          ex_mem_write,
  output logic          ex_alu_src,
  output logic [4:0]    ex_alu_control,
  output logic          ex_reg_write,
  output logic [DW-1:0] ex_pc_count,
  output logic [DW-1:0] ex_RD1,
  output logic [DW-1:0] ex_RD2,
  output logic [DW-1:0] ex_signImm,
  output logic [RW-1:0] ex_rd,
  output logic [1:0]    mem_mem_to_reg,
  output logic          mem_mem_write,
  output logic          mem_reg_write,
  output logic [DW-1:0] mem_pc_count,
  output logic [DW-1:0] mem_RD2,
  output logic [DW-1:0] mem_signImm,
  output logic [DW-1:0] mem_aluResult,
  output logic [RW-1:0] mem_rd
);

  ctrl_t w_ctrl;

  control_decoder u_dec (
    .opcode      (opcode),
    .pc_src      (pc_src),
    .imm_src     (imm_src),
    .mem_to_reg  (w_ctrl.mem_to_reg),
    .mem_write   (w_ctrl.mem_write),
    .alu_src     (w_ctrl.alu_src),
    .alu_control (w_ctrl.alu_control),
    .reg_write   (w_ctrl.reg_write)
  );

  // ID/EX
  ctrl_t         r_ex_ctrl;
  logic [DW-1:0] r_ex_pc, r_ex_rd1, r_ex_rd2, r_ex_imm;
  logic [RW-1:0] r_ex_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_ctrl <= '0;
      r_ex_pc   <= '0;
      r_ex_rd1  <= '0;
      r_ex_rd2  <= '0;
      r_ex_imm  <= '0;
      r_ex_rd   <= '0;
    end else begin
      r_ex_ctrl <= w_ctrl;
      r_ex_pc   <= pc_count;
      r_ex_rd1  <= RD1;
      r_ex_rd2  <= RD2;
      r_ex_imm  <= signImm;
      r_ex_rd   <= rd;
    end
  end

  // EX/MEM: alu_src/alu_control are consumed in Execute and not carried on
  logic [1:0]    r_mem_m2r;
  logic          r_mem_mw, r_mem_rw;
  logic [DW-1:0] r_mem_pc, r_mem_rd2, r_mem_imm, r_mem_alu;
  logic [RW-1:0] r_mem_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_m2r <= '0;
      r_mem_mw  <= 1'b0;
      r_mem_rw  <= 1'b0;
      r_mem_pc  <= '0;
      r_mem_rd2 <= '0;
      r_mem_imm <= '0;
      r_mem_alu <= '0;
      r_mem_rd  <= '0;
    end else begin
      r_mem_m2r <= r_ex_ctrl.mem_to_reg;
      r_mem_mw  <= r_ex_ctrl.mem_write;
      r_mem_rw  <= r_ex_ctrl.reg_write;
      r_mem_pc  <= r_ex_pc;
      r_mem_rd2 <= r_ex_rd2;
      r_mem_imm <= r_ex_imm;
      r_mem_alu <= alu_Result;
      r_mem_rd  <= r_ex_rd;
    end
  end

  assign ex_mem_to_reg  = r_ex_ctrl.mem_to_reg;
  assign ex_mem_write   = r_ex_ctrl.mem_write;
  assign ex_alu_src     = r_ex_ctrl.alu_src;
  assign ex_alu_control = r_ex_ctrl.alu_control;
  assign ex_reg_write   = r_ex_ctrl.reg_write;
  assign ex_pc_count    = r_ex_pc;
  assign ex_RD1         = r_ex_rd1;
  assign ex_RD2         = r_ex_rd2;
  assign ex_signImm     = r_ex_imm;
  assign ex_rd          = r_ex_rd;

  assign mem_mem_to_reg = r_mem_m2r;
  assign mem_mem_write  = r_mem_mw;
  assign mem_reg_write  = r_mem_rw;
  assign mem_pc_count   = r_mem_pc;
  assign mem_RD2        = r_mem_rd2;
  assign mem_signImm    = r_mem_imm;
  assign mem_aluResult  = r_mem_alu;
  assign mem_rd         = r_mem_rd;

endmodule

// File: tb/tb_control_id_ex_mem.sv
module tb_control_id_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        pc_src;
  logic [1:0]  imm_src;
  logic [31:0] pc_count, RD1, RD2, signImm, alu_Result;
  logic [4:0]  rd;
  logic [1:0]  ex_mem_to_reg, mem_mem_to_reg;
  logic        ex_mem_write, ex_alu_src, ex_reg_write;
  logic [4:0]  ex_alu_control, ex_rd, mem_rd;
  logic [31:0] ex_pc_count, ex_RD1, ex_RD2, ex_signImm;
  logic        mem_mem_write, mem_reg_write;
  logic [31:0] mem_pc_count, mem_RD2, mem_signImm, mem_aluResult;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_id_ex_mem dut (
    .clk(clk), .rst(rst), .opcode(opcode), .pc_src(pc_src), .imm_src(imm_src),
    .pc_count(pc_count), .RD1(RD1), .RD2(RD2), .signImm(signImm), .rd(rd),
    .alu_Result(alu_Result),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_alu_control(ex_alu_control),
    .ex_reg_write(ex_reg_write), .ex_pc_count(ex_pc_count), .ex_RD1(ex_RD1),
    .ex_RD2(ex_RD2), .ex_signImm(ex_signImm), .ex_rd(ex_rd),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_pc_count(mem_pc_count),
    .mem_RD2(mem_RD2), .mem_signImm(mem_signImm),
    .mem_aluResult(mem_aluResult), .mem_rd(mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, then step clear of it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] ex_ctl();
    return {ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_alu_control, ex_reg_write};
  endfunction

  function automatic logic [31:0] ex_all();
    return {ex_ctl(), ex_pc_count[3:0], ex_RD1[3:0], ex_RD2[3:0], ex_signImm[3:0], ex_rd[1:0]} |
           {30'd0, |{ex_pc_count, ex_RD1, ex_RD2, ex_signImm, ex_rd}, 1'b0};
  endfunction

  function automatic logic [31:0] mem_or();
    return {30'd0, mem_mem_to_reg} | {31'd0, mem_mem_write} | {31'd0, mem_reg_write} |
           mem_pc_count | mem_RD2 | mem_signImm | mem_aluResult | {27'd0, mem_rd};
  endfunction

  // Decode table: {pc_src, imm_src, mem_to_reg, mem_write, alu_src, alu_control, reg_write}
  logic [5:0]  dec_op  [12] = '{6'h00, 6'h03, 6'h08, 6'h14, 6'h18, 6'h20,
                                6'h21, 6'h22, 6'h30, 6'h3F, 6'h09, 6'h19};
  logic [12:0] dec_exp [12] = '{13'h000, 13'h107, 13'h111, 13'h149, 13'h151, 13'h443,
                                13'h4C2, 13'hA01, 13'h1800, 13'h000, 13'h000, 13'h000};

  // Back-to-back: ADD, STORE, MOVI, NOP
  logic [5:0] b2b_op  [4] = '{6'h01, 6'h21, 6'h22, 6'h00};
  logic [9:0] b2b_ex  [4] = '{10'h103, 10'h0C2, 10'h201, 10'h000};
  logic [3:0] b2b_mem [4] = '{4'h5, 4'h2, 4'h9, 4'h0};

  initial begin
    logic [2:0] comb;
    rst = 1'b0;
    opcode = 6'h20;
    pc_count = '1; RD1 = '1; RD2 = '1; signImm = '1; rd = '1; alu_Result = '1;
    #12;
    chk("reset_ex", {22'd0, ex_ctl()} | ex_pc_count | ex_rd, 32'd0);
    chk("reset_mem", mem_or(), 32'd0);
    rst = 1'b1;
    tick(); tick();
    chk("pre_rst_ex_rd1", ex_RD1, 32'hFFFF_FFFF);
    chk("pre_rst_mem_rw", {31'd0, mem_reg_write}, 32'd1);
    // async clear between edges
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ex", {22'd0, ex_ctl()} | ex_pc_count | ex_RD1 | ex_RD2 | ex_signImm | ex_rd, 32'd0);
    chk("async_rst_mem", mem_or(), 32'd0);
    tick();
    chk("held_rst_ex", {22'd0, ex_ctl()} | ex_RD1 | ex_rd, 32'd0);
    chk("held_rst_mem", mem_or(), 32'd0);
    rst = 1'b1;
    pc_count = '0; RD1 = '0; RD2 = '0; signImm = '0; rd = '0; alu_Result = '0;

    // decode sweep
    for (int i = 0; i < 12; i++) begin
      opcode = dec_op[i];
      #1;
      comb = {pc_src, imm_src};
      tick();
      chk($sformatf("dec_%02h", dec_op[i]), {19'd0, comb, ex_ctl()}, {19'd0, dec_exp[i]});
    end
    // remaining unused opcodes must be full NOPs (pc_src/imm_src and fields)
    for (int op = 6'h23; op < 6'h30; op++) begin
      opcode = 6'(op);
      #1;
      comb = {pc_src, imm_src};
      tick();
      chk($sformatf("nop_%02h", op), {19'd0, comb, ex_ctl()}, 32'd0);
    end

    // latency + ALU path
    opcode = 6'h20; pc_count = 32'h10; RD1 = 32'd5; RD2 = 32'd7; signImm = 32'd4; rd = 5'd9;
    tick();
    chk("lat1_m2r", {30'd0, ex_mem_to_reg}, 32'd0);
    chk("lat1_rw", {31'd0, ex_reg_write}, 32'd1);
    chk("lat1_rd1", ex_RD1, 32'd5);
    chk("lat1_rd2", ex_RD2, 32'd7);
    opcode = 6'h00; pc_count = '0; RD1 = '0; RD2 = '0; signImm = '0; rd = '0;
    alu_Result = 32'hAA;
    tick();
    chk("lat2_rd", {27'd0, mem_rd}, 32'd9);
    chk("lat2_pc", mem_pc_count, 32'h10);
    chk("lat2_imm", mem_signImm, 32'd4);
    chk("lat2_rd2", mem_RD2, 32'd7);
    chk("lat2_rw", {31'd0, mem_reg_write}, 32'd1);
    chk("alu_res", mem_aluResult, 32'hAA);
    chk("lat2_ex_clr", {22'd0, ex_ctl()} | ex_RD1, 32'd0);
    alu_Result = 32'h0;
    tick();
    chk("alu_res_next", mem_aluResult, 32'h0);

    // back-to-back
    for (int k = 0; k < 5; k++) begin
      opcode = (k < 4) ? b2b_op[k] : 6'h00;
      rd     = (k < 4) ? 5'(k + 1) : 5'd0;
      tick();
      if (k < 4) begin
        chk($sformatf("b2b_ex%0d", k), {22'd0, ex_ctl()}, {22'd0, b2b_ex[k]});
        chk($sformatf("b2b_exrd%0d", k), {27'd0, ex_rd}, 32'(k + 1));
      end
      if (k > 0) begin
        chk($sformatf("b2b_mem%0d", k),
            {28'd0, mem_mem_to_reg, mem_mem_write, mem_reg_write}, {28'd0, b2b_mem[k-1]});
        chk($sformatf("b2b_memrd%0d", k), {27'd0, mem_rd}, 32'(k));
      end
    end

    // mid-stream reset with STORE in EX/MEM
    opcode = 6'h21; rd = 5'd3;
    tick();
    opcode = 6'h00; rd = 5'd0;
    tick();
    chk("store_in_mem", {31'd0, mem_mem_write}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_mw", {31'd0, mem_mem_write}, 32'd0);
    chk("mid_rst_mem", mem_or(), 32'd0);
    tick();
    chk("mid_rst_hold", mem_or() | {22'd0, ex_ctl()}, 32'd0);
    #2 rst = 1'b1;
    opcode = 6'h22; rd = 5'd7; signImm = 32'h123;
    tick();
    chk("refill_ex_m2r", {30'd0, ex_mem_to_reg}, 32'd2);
    chk("refill_ex_rd", {27'd0, ex_rd}, 32'd7);
    chk("refill_mem_empty", mem_or(), 32'd0);
    opcode = 6'h00; rd = 5'd0; signImm = 32'h0;
    tick();
    chk("refill_mem_rd", {27'd0, mem_rd}, 32'd7);
    chk("refill_mem_imm", mem_signImm, 32'h123);
    chk("refill_mem_m2r", {30'd0, mem_mem_to_reg}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_id_ex_mem.md
# control_id_ex_mem

Decode-stage control unit plus the ID/EX and EX/MEM pipeline registers of the 5-stage 32-bit core. The control unit turns the 6-bit opcode into datapath control signals. Those signals, along with the decode-stage operands, are carried one stage per clock into Execute and then into Memory. The block sits between the decoder/register file and the ALU/data RAM.

## Interface
- DATA_W, 32, width of PC, operands, immediate, ALU result
- REG_W, 5, register-index width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- opcode  in  6  decode-stage opcode
- pc_src  out  1  combinational; 1 = load PC with branch target
- imm_src  out  2  combinational immediate select: 0 = imm10, 1 = imm15, 2 = imm20
- pc_count, RD1, RD2, signImm  in  DATA_W  decode-stage PC, register operands, extended immediate
- rd  in  REG_W  decode-stage destination register
- alu_Result  in  DATA_W  Execute-stage ALU output
- ex_mem_to_reg 2, ex_mem_write 1, ex_alu_src 1, ex_alu_control 5, ex_reg_write 1, ex_pc_count/ex_RD1/ex_RD2/ex_signImm DATA_W, ex_rd REG_W  out  ID/EX register contents
- mem_mem_to_reg 2, mem_mem_write 1, mem_reg_write 1, mem_pc_count/mem_RD2/mem_signImm/mem_aluResult DATA_W, mem_rd REG_W  out  EX/MEM register contents

## Operation
- The control unit is purely combinational. Its default for every field is 0, which is a NOP.
- mem_to_reg encoding: 0 = memory data, 1 = ALU result, 2 = signImm. alu_src: 0 = RD2, 1 = signImm.
- Opcodes 0x01–0x08 (ADD, SUB, AND, OR, XOR, SLL, SRL, MUL): reg_write=1, mem_to_reg=1, alu_src=0, alu_control={1'b0, opcode[3:0]}.
- Opcodes 0x11–0x18 (immediate forms of the same ops): reg_write=1, mem_to_reg=1, alu_src=1, imm_src=0, alu_control={1'b0, opcode[3:0]}.
- 0x20 LOAD: reg_write=1, mem_to_reg=0, alu_src=1, imm_src=1, alu_control=1 (ADD).
- 0x21 STORE: mem_write=1, reg_write=0, alu_src=1, imm_src=1, alu_control=1.
- 0x22 MOVI: reg_write=1, mem_to_reg=2, imm_src=2, alu_control=0.
- 0x30 JUMP: pc_src=1, imm_src=2, no writes.
- 0x00 and every other opcode: all outputs 0.
- ID/EX register captures control fields (mem_to_reg, mem_write, alu_src, alu_control, reg_write) and pc_count, RD1, RD2, signImm, rd.
- EX/MEM register captures from ID/EX: mem_to_reg, mem_write, reg_write, pc_count, RD2, signImm, rd. It also captures the alu_Result input.
- There is no stall, flush or enable. Both registers load on every clock.

## Timing
- Control outputs settle in the same cycle as the opcode; there is no register.
- ID/EX outputs are the decode inputs delayed by 1 cycle. EX/MEM outputs are the decode inputs delayed by 2 cycles.
- alu_Result is sampled at the edge ending the Execute cycle and appears on mem_aluResult 1 cycle later.
- Reset (rst=0) asynchronously clears every register bit of both stages to 0, including mid-operation, independent of clk. This yields NOP semantics: reg_write=0, mem_write=0.
- Registers capture inputs on the first rising edge after rst returns to 1.
- Outputs change only on rising clk or on rst assertion.

## Structure
- Shared package: opcode constants, the mem_to_reg, alu_src and imm_src encodings, ALU op codes, and DATA_W/REG_W.
- Sub-module: control_decoder, the combinational opcode-to-control mapping.
- The two pipeline registers live in the top as two always_ff blocks with async clear. A generic pipe_reg sub-module is optional.

## Test plan
- Reset: drive all inputs to 0xFFFF_FFFF, then set rst=0 between edges. All ex_* and mem_* outputs must go to 0 immediately and stay at 0 while reset is held.
- Decode sweep over opcodes 0x00–0x3F:
  - 0x03 → reg_write=1, mem_to_reg=1, alu_src=0, alu_control=3.
  - 0x21 → mem_write=1, alu_src=1, imm_src=1.
  - 0x30 → pc_src=1.
  - 0x3F → all 0.
- Latency, with opcode 0x20, pc_count=0x10, RD1=5, RD2=7, signImm=4, rd=9:
  - 1 cycle later: ex_mem_to_reg=0, ex_reg_write=1, ex_RD1=5.
  - 2 cycles later: mem_rd=9, mem_pc_count=0x10, mem_signImm=4.
- ALU path: drive alu_Result=0x0000_00AA during the Execute cycle → mem_aluResult=0xAA on the next edge.
- Back-to-back: feed ADD, STORE, MOVI, NOP on consecutive cycles. Each stage must show the matching control set in order, with no mixing of fields between instructions.
- Mid-stream reset: assert rst while a STORE sits in EX/MEM → mem_mem_write drops to 0 immediately. After release, the pipeline refills from the current inputs.
